// File: rtl/spi_fifo_bridge.sv
// spi_fifo_bridge: host TX/RX byte FIFOs around a byte transceiver,
// with a throttled feeder FSM and a collector FSM.
module spi_fifo_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk)
    if (push_ok && !flush)
      mem[wp] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok)
        wp <= wp + 1'b1;
      if (pop_ok)
        rp <= rp + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module spi_fifo_bridge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] host_wdata,
  input  logic             host_we,
  output logic             tx_full,
  output logic [AW:0]      tx_count,
  output logic [WIDTH-1:0] host_rdata,
  input  logic             host_re,
  output logic             rx_empty,
  output logic [AW:0]      rx_count,
  input  logic             flush,
  input  logic             rx_discard,
  input  logic             flag_clr,
  output logic             tx_ovf,
  output logic             rx_udf,
  output logic             busy,
  output logic [WIDTH-1:0] xcv_tx_data,
  output logic             xcv_wr_en,
  input  logic             xcv_tx_not_empty,
  input  logic [WIDTH-1:0] xcv_rx_data,
  output logic             xcv_read,
  input  logic             xcv_rx_not_empty
);
  typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_GUARD} f_state_t;
  typedef enum logic [1:0] {C_IDLE, C_READ, C_GUARD} c_state_t;

  f_state_t         f_state;
  c_state_t         c_state;
  logic [2:0]       in_flight;
  logic [WIDTH-1:0] tx_head;
  logic             tx_empty;
  logic             tx_pop;
  logic             rx_full;
  logic             rx_push;
  logic             can_issue;

  assign tx_pop  = (f_state == F_ISSUE);
  assign rx_push = (c_state == C_READ) && !rx_discard && !rx_full;

  // Never issue more bytes than the RX FIFO can still absorb.
  assign can_issue = !tx_empty && !xcv_tx_not_empty &&
    (rx_discard || ((int'(rx_count) + int'(in_flight)) < DEPTH));

  assign busy = !tx_empty || (in_flight != '0) ||
    (f_state != F_IDLE) || (c_state != C_IDLE);

  spi_fifo_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(host_we), .pop(tx_pop), .wdata(host_wdata),
    .rdata(tx_head), .empty(tx_empty), .full(tx_full),
    .count(tx_count)
  );

  spi_fifo_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(rx_push), .pop(host_re), .wdata(xcv_rx_data),
    .rdata(host_rdata), .empty(rx_empty), .full(rx_full),
    .count(rx_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state     <= F_IDLE;
      xcv_wr_en   <= 1'b0;
      xcv_tx_data <= '0;
    end else begin
      xcv_wr_en <= 1'b0;
      unique case (f_state)
        F_IDLE: if (can_issue) begin
          f_state     <= F_ISSUE;
          xcv_wr_en   <= 1'b1;
          xcv_tx_data <= tx_head;
        end
        F_ISSUE: f_state <= F_GUARD;
        F_GUARD: f_state <= F_IDLE;
        default: f_state <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state  <= C_IDLE;
      xcv_read <= 1'b0;
    end else begin
      xcv_read <= 1'b0;
      unique case (c_state)
        C_IDLE: if (xcv_rx_not_empty) begin
          c_state  <= C_READ;
          xcv_read <= 1'b1;
        end
        C_READ:  c_state <= C_GUARD;
        C_GUARD: c_state <= C_IDLE;
        default: c_state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      unique case ({xcv_wr_en, xcv_read})
        2'b10:   in_flight <= in_flight + 3'd1;
        2'b01:   in_flight <= in_flight - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= (host_we && tx_full) || (tx_ovf && !flag_clr);
      rx_udf <= (host_re && rx_empty) || (rx_udf && !flag_clr);
    end
  end
endmodule

// File: tb/tb_spi_fifo_bridge.sv
// tb_spi_fifo_bridge: scoreboard bench with a loop-back transceiver
// model that takes a few cycles per byte.
module tb_spi_fifo_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] host_wdata = '0;
  logic       host_we = 1'b0;
  logic       host_re = 1'b0;
  logic       flush = 1'b0;
  logic       rx_discard = 1'b0;
  logic       flag_clr = 1'b0;
  logic       tx_full, rx_empty, tx_ovf, rx_udf, busy;
  logic [3:0] tx_count, rx_count;
  logic [7:0] host_rdata, xcv_tx_data, xcv_rx_data;
  logic       xcv_wr_en, xcv_read;
  logic       xcv_tx_not_empty, xcv_rx_not_empty;

  logic       hold = 1'b0;
  logic       rx_hold = 1'b0;
  logic [7:0] mq [16];
  logic [3:0] mwp, mrp;
  logic [1:0] mcnt;
  logic [7:0] msh;
  logic [7:0] mon_e;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int checks = 0;
  int fails = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  always #5 clk = ~clk;

  spi_fifo_bridge #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wdata(host_wdata), .host_we(host_we),
    .tx_full(tx_full), .tx_count(tx_count),
    .host_rdata(host_rdata), .host_re(host_re),
    .rx_empty(rx_empty), .rx_count(rx_count),
    .flush(flush), .rx_discard(rx_discard), .flag_clr(flag_clr),
    .tx_ovf(tx_ovf), .rx_udf(rx_udf), .busy(busy),
    .xcv_tx_data(xcv_tx_data), .xcv_wr_en(xcv_wr_en),
    .xcv_tx_not_empty(xcv_tx_not_empty),
    .xcv_rx_data(xcv_rx_data), .xcv_read(xcv_read),
    .xcv_rx_not_empty(xcv_rx_not_empty)
  );

  // Loop-back transceiver: shifts for 3 cycles, then queues the byte.
  assign xcv_tx_not_empty = hold || (mcnt != 2'd0);
  assign xcv_rx_not_empty = !rx_hold && (mwp != mrp);
  assign xcv_rx_data      = mq[mrp];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 2'd0;
      mwp  <= 4'd0;
      mrp  <= 4'd0;
      msh  <= 8'd0;
    end else begin
      if (xcv_wr_en) begin
        msh  <= xcv_tx_data;
        mcnt <= 2'd3;
      end else if (mcnt != 2'd0) begin
        mcnt <= mcnt - 2'd1;
        if (mcnt == 2'd1) begin
          mq[mwp] <= msh;
          mwp     <= mwp + 4'd1;
        end
      end
      if (xcv_read && (mwp != mrp))
        mrp <= mrp + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (xcv_wr_en) begin
        wr_pulses++;
        checks++;
        if (exp_tx.size() == 0) begin
          fails++;
          $display("FAIL tx_issue: got unexpected byte %h", xcv_tx_data);
        end else begin
          mon_e = exp_tx.pop_front();
          if (xcv_tx_data !== mon_e) begin
            fails++;
            $display("FAIL tx_issue: got %h want %h", xcv_tx_data, mon_e);
          end
        end
      end
      if (xcv_read)
        rd_pulses++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accept, input bit to_rx);
    host_wdata = b;
    host_we    = 1'b1;
    if (accept) begin
      exp_tx.push_back(b);
      if (to_rx)
        exp_rx.push_back(b);
    end
    tick();
    host_we = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    checks++;
    if (rx_empty !== 1'b0 || exp_rx.size() == 0) begin
      fails++;
      $display("FAIL %s: rx_empty=%b, %0d bytes expected", tag, rx_empty, exp_rx.size());
    end else begin
      e = exp_rx.pop_front();
      if (host_rdata !== e) begin
        fails++;
        $display("FAIL %s: rdata got %h want %h", tag, host_rdata, e);
      end
      host_re = 1'b1;
      tick();
      host_re = 1'b0;
    end
  endtask

  task automatic wait_rx(input int budget);
    for (int i = 0; i < budget && rx_empty; i++)
      tick();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && (busy !== 1'b0 || mcnt != 2'd0 || mwp != mrp); i++)
      tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy got %b want 0 after %0d cycles", tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({tx_count, rx_count, tx_full, rx_empty, xcv_wr_en, xcv_read,
         tx_ovf, rx_udf, busy, xcv_tx_data} !== {4'd0, 4'd0, 7'b0100000, 8'h00}) begin
      fails++;
      $display("FAIL reset_state: txc=%0d rxc=%0d full=%b empty=%b wr=%b rd=%b ovf=%b udf=%b busy=%b txd=%h",
        tx_count, rx_count, tx_full, rx_empty, xcv_wr_en, xcv_read, tx_ovf, rx_udf, busy, xcv_tx_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [7:0] b);
    host_wdata = b;
    host_we    = 1'b1;
    exp_tx.push_back(b);
    exp_rx.push_back(b);
    tick();
    host_we = 1'b0;
    checks++;
    if (tx_count !== 4'd1 || xcv_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL single_n1: tx_count=%0d wr_en=%b want 1,0", tx_count, xcv_wr_en);
    end
    tick();
    checks++;
    if (xcv_wr_en !== 1'b1 || xcv_tx_data !== b) begin
      fails++;
      $display("FAIL single_n2: wr_en=%b data=%h want 1,%h", xcv_wr_en, xcv_tx_data, b);
    end
    for (int i = 0; i < 20 && !xcv_rx_not_empty; i++)
      tick();
    checks++;
    if (xcv_rx_not_empty !== 1'b1) begin
      fails++;
      $display("FAIL single_loopback: rx_not_empty got %b want 1", xcv_rx_not_empty);
    end
    tick();
    checks++;
    if (xcv_read !== 1'b1 || rx_empty !== 1'b1) begin
      fails++;
      $display("FAIL single_m1: read=%b rx_empty=%b want 1,1", xcv_read, rx_empty);
    end
    tick();
    checks++;
    if (rx_count !== 4'd1 || rx_empty !== 1'b0) begin
      fails++;
      $display("FAIL single_m2: rx_count=%0d rx_empty=%b want 1,0", rx_count, rx_empty);
    end
    pop_check("single_rdata");
    wait_idle(50, "single_idle");
  endtask

  task automatic test_overflow();
    hold = 1'b1;
    for (int i = 0; i < 8; i++)
      push(8'(i), 1'b1, 1'b1);
    checks++;
    if (tx_full !== 1'b1 || tx_count !== 4'd8) begin
      fails++;
      $display("FAIL ovf_fill: full=%b count=%0d want 1,8", tx_full, tx_count);
    end
    push(8'h08, 1'b0, 1'b0);
    checks++;
    if (tx_ovf !== 1'b1 || tx_count !== 4'd8) begin
      fails++;
      $display("FAIL ovf_flag: ovf=%b count=%0d want 1,8", tx_ovf, tx_count);
    end
    hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_rx(60);
      pop_check("ovf_order");
    end
    wait_idle(100, "ovf_idle");
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (tx_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf got %b want 0", tx_ovf);
    end
  endtask

  task automatic test_throttle();
    int base;
    base = wr_pulses;
    for (int i = 0; i < 12; i++) begin
      push(8'h40 + 8'(i), 1'b1, 1'b1);
      repeat (5) tick();
    end
    repeat (40) tick();
    checks++;
    if (wr_pulses - base != 8 || rx_count !== 4'd8 || tx_count !== 4'd4) begin
      fails++;
      $display("FAIL throttle_hold: issued=%0d rx=%0d tx=%0d want 8,8,4",
        wr_pulses - base, rx_count, tx_count);
    end
    pop_check("throttle_pop");
    pop_check("throttle_pop");
    repeat (40) tick();
    checks++;
    if (wr_pulses - base != 10 || rx_count !== 4'd8 || tx_count !== 4'd2) begin
      fails++;
      $display("FAIL throttle_resume: issued=%0d rx=%0d tx=%0d want 10,8,2",
        wr_pulses - base, rx_count, tx_count);
    end
    for (int i = 0; i < 10; i++) begin
      wait_rx(60);
      pop_check("throttle_drain");
    end
    wait_idle(100, "throttle_idle");
  endtask

  task automatic test_discard();
    int wbase;
    int rbase;
    wbase = wr_pulses;
    rbase = rd_pulses;
    rx_discard = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(8'h80 + 8'(i), 1'b1, 1'b0);
      repeat (5) tick();
    end
    wait_idle(200, "discard_idle");
    checks++;
    if (wr_pulses - wbase != 12 || rd_pulses - rbase != 12 || rx_count !== 4'd0) begin
      fails++;
      $display("FAIL discard: issued=%0d read=%0d rx=%0d want 12,12,0",
        wr_pulses - wbase, rd_pulses - rbase, rx_count);
    end
    rx_discard = 1'b0;
  endtask

  task automatic test_underflow();
    host_re = 1'b1;
    tick();
    host_re = 1'b0;
    checks++;
    if (rx_udf !== 1'b1) begin
      fails++;
      $display("FAIL udf_set: udf got %b want 1", rx_udf);
    end
    host_re  = 1'b1;
    flag_clr = 1'b1;
    tick();
    host_re  = 1'b0;
    flag_clr = 1'b0;
    checks++;
    if (rx_udf !== 1'b1) begin
      fails++;
      $display("FAIL udf_set_clr: udf got %b want 1", rx_udf);
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (rx_udf !== 1'b0) begin
      fails++;
      $display("FAIL udf_clear: udf got %b want 0", rx_udf);
    end
    for (int i = 0; i < 3; i++) begin
      push(8'hC0 + 8'(i), 1'b1, 1'b1);
      repeat (5) tick();
    end
    wait_idle(100, "udf_idle");
    checks++;
    if (rx_count !== 4'd3) begin
      fails++;
      $display("FAIL udf_fill: rx_count got %0d want 3", rx_count);
    end
    push(8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 40 && !xcv_read; i++)
      tick();
    checks++;
    if (xcv_read !== 1'b1) begin
      fails++;
      $display("FAIL udf_wait_read: read got %b want 1", xcv_read);
    end
    pop_check("udf_simul_pop");
    checks++;
    if (rx_count !== 4'd3) begin
      fails++;
      $display("FAIL udf_simul: rx_count got %0d want 3", rx_count);
    end
    for (int i = 0; i < 3; i++)
      pop_check("udf_drain");
    wait_idle(50, "udf_end_idle");
  endtask

  task automatic test_flush();
    int base;
    base = wr_pulses;
    hold = 1'b1;
    for (int i = 0; i < 3; i++)
      push(8'hF0 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (tx_count !== 4'd3) begin
      fails++;
      $display("FAIL flush_fill: tx_count got %0d want 3", tx_count);
    end
    flush      = 1'b1;
    host_we    = 1'b1;
    host_wdata = 8'hFF;
    tick();
    flush   = 1'b0;
    host_we = 1'b0;
    checks++;
    if (tx_count !== 4'd0 || rx_count !== 4'd0 || tx_ovf !== 1'b0) begin
      fails++;
      $display("FAIL flush: tx=%0d rx=%0d ovf=%b want 0,0,0", tx_count, rx_count, tx_ovf);
    end
    hold = 1'b0;
    repeat (20) tick();
    checks++;
    if (wr_pulses != base || busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_quiet: issued=%0d busy=%b want 0,0", wr_pulses - base, busy);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    hold    = 1'b1;
    rx_hold = 1'b1;
    for (int i = 0; i < 7; i++)
      push(8'hE0 + 8'(i), 1'b1, 1'b1);
    base = wr_pulses;
    hold = 1'b0;
    for (int i = 0; i < 60 && (wr_pulses - base) < 2; i++)
      tick();
    hold = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_pulses - base != 2 || tx_count !== 4'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_setup: issued=%0d tx=%0d busy=%b want 2,5,1",
        wr_pulses - base, tx_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_count, rx_count, tx_full, rx_empty, xcv_wr_en, xcv_read,
         tx_ovf, rx_udf, busy, xcv_tx_data} !== {4'd0, 4'd0, 7'b0100000, 8'h00}) begin
      fails++;
      $display("FAIL rstmid_state: txc=%0d rxc=%0d full=%b empty=%b wr=%b rd=%b ovf=%b udf=%b busy=%b txd=%h",
        tx_count, rx_count, tx_full, rx_empty, xcv_wr_en, xcv_read, tx_ovf, rx_udf, busy, xcv_tx_data);
    end
    exp_tx.delete();
    exp_rx.delete();
    tick();
    hold    = 1'b0;
    rx_hold = 1'b0;
    rst_n   = 1'b1;
    test_single(8'h3C);
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_overflow();
    test_throttle();
    test_discard();
    test_underflow();
    test_flush();
    test_reset_mid();
    repeat (5) tick();
    checks++;
    if (exp_tx.size() != 0 || exp_rx.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: tx=%0d rx=%0d want 0,0", exp_tx.size(), exp_rx.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_fifo_bridge.md
SPI_FIFO_BRIDGE -- requirements
Module: spi_fifo_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 8, byte width; equals transceiver WIDTH.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, 2..64.
REQ-003 SHALL have ports clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have host TX ports: host_wdata in WIDTH; host_we in 1; tx_full out 1; tx_count out log2(DEPTH)+1.
REQ-006 SHALL have host RX ports: host_rdata out WIDTH, the RX head, valid while rx_empty=0; host_re in 1; rx_empty out 1; rx_count out log2(DEPTH)+1.
REQ-007 SHALL have control ports: flush in 1; rx_discard in 1; flag_clr in 1; tx_ovf out 1; rx_udf out 1; busy out 1.
REQ-008 SHALL have transceiver-side ports: xcv_tx_data out WIDTH; xcv_wr_en out 1; xcv_tx_not_empty in 1; xcv_rx_data in WIDTH; xcv_read out 1; xcv_rx_not_empty in 1.

Function
REQ-009 TX FIFO and RX FIFO SHALL each be DEPTH-entry synchronous FIFOs with wrapping pointers and exact occupancy counts.
REQ-010 host_we with tx_full=0 SHALL push host_wdata; with tx_full=1 it SHALL be dropped and set tx_ovf.
REQ-011 host_re with rx_empty=0 SHALL pop; with rx_empty=1 it SHALL be ignored and set rx_udf.
REQ-012 tx_ovf and rx_udf SHALL be sticky until flag_clr; a set and flag_clr in the same cycle leaves the flag at 1.
REQ-013 Simultaneous push and pop on one FIFO SHALL both take effect, count unchanged; on an empty FIFO only the push takes effect.
REQ-014 An in_flight counter of 3 bits SHALL count bytes issued to the transceiver but not yet read back: +1 per xcv_wr_en cycle, -1 per xcv_read cycle, net 0 when both occur.
REQ-015 Feeder FSM SHALL have states F_IDLE, F_ISSUE, F_GUARD.
REQ-016 F_IDLE->F_ISSUE SHALL require TX FIFO non-empty, xcv_tx_not_empty=0, and either rx_discard=1 or rx_count+in_flight<DEPTH.
REQ-017 F_ISSUE SHALL last one cycle: xcv_wr_en=1, xcv_tx_data=TX head, TX pop; then F_GUARD for one cycle, then F_IDLE.
REQ-018 xcv_wr_en and xcv_read SHALL be decoded only from state registers, with no combinational path from inputs.
REQ-019 Collector FSM SHALL have states C_IDLE, C_READ, C_GUARD; C_IDLE->C_READ when xcv_rx_not_empty=1.
REQ-020 C_READ SHALL last one cycle: xcv_read=1, push xcv_rx_data to the RX FIFO unless rx_discard=1; then C_GUARD for one cycle, then C_IDLE.
REQ-021 The throttle in REQ-016 SHALL guarantee the RX FIFO is never full in C_READ with rx_discard=0; no received byte SHALL be lost.
REQ-022 flush SHALL empty both FIFOs in one cycle, overriding same-cycle host_we, host_re and RX push; it SHALL NOT change in_flight, FSM states, or flags.
REQ-023 busy SHALL be 1 while the TX FIFO is non-empty, in_flight!=0, or either FSM is not idle.
REQ-024 Latency: host_we in cycle N into an empty TX FIFO with the transceiver idle SHALL give tx_count=1 in N+1 and xcv_wr_en=1 in N+2.
REQ-025 Latency: xcv_rx_not_empty rising in cycle M SHALL give xcv_read=1 in M+1, and rx_count incremented and rx_empty=0 in M+2.

Reset
REQ-026 While rst_n=0, the block SHALL set: FIFOs empty, tx_count=rx_count=0, tx_full=0, rx_empty=1, in_flight=0, both FSMs idle, xcv_wr_en=xcv_read=0, tx_ovf=rx_udf=0, busy=0, xcv_tx_data=0.
REQ-027 Reset asserted mid-transfer SHALL discard all queued and in-flight bytes; operation SHALL resume from the idle state on the first edge after release.

Verification
REQ-028 Push 0xA5 into idle block, transceiver model idle -> xcv_wr_en pulse 2 cycles later with xcv_tx_data=0xA5; loop-back model returns 0xA5; rx_count=1, host_rdata=0xA5.
REQ-029 Push 8 bytes 0x00..0x07 then a 9th byte -> tx_ovf=1, 9th byte dropped; all 8 bytes received in order; flag_clr -> tx_ovf=0.
REQ-030 rx_discard=0 and host never reads; push 12 bytes -> exactly 8 xcv_wr_en pulses, rx_count=8, 4 bytes held in TX; pop 2 -> 2 more issued.
REQ-031 rx_discard=1 and 12 bytes pushed -> 12 issued and read, rx_count stays 0, in_flight returns to 0, busy falls.
REQ-032 host_re with RX empty -> rx_udf=1; host_re and RX push in same cycle at rx_count=3 -> rx_count stays 3.
REQ-033 Assert rst_n=0 with in_flight=2 and TX count=5 -> all outputs at REQ-026 values; a new push after release behaves as in REQ-028.
